// File: rtl/mem_byte_ctrl_pkg.sv
// Shared constants, state encoding and byte-lane helpers for mem_byte_ctrl.
// Lane k of a word sits in bits [31-8k:24-8k] and is selected by sel bit 3-k.
package mem_byte_ctrl_pkg;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam int   RAM_ADDR_BUS = 17;

    typedef enum logic [1:0] {
        MBC_IDLE = 2'd0,
        MBC_RUN  = 2'd1,
        MBC_TAIL = 2'd2,
        MBC_DONE = 2'd3
    } mbc_state_t;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] off,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (off)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

    // Byte, aligned halfword and full word patterns only.
    function automatic logic sel_legal(input logic [3:0] sel);
        logic ok;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_byte_ctrl_lane_scan.sv
// lane_scan: finds the lowest selected byte offset after (or at, when i_incl) i_cur.
// o_last=1 means no such offset exists.
module lane_scan (
    input  logic [3:0] i_sel,
    input  logic [1:0] i_cur,
    input  logic       i_incl,
    output logic [1:0] o_next,
    output logic       o_last
);

    always_comb begin
        o_next = 2'd0;
        o_last = 1'b1;
        // Descending scan so the lowest qualifying offset is the one that sticks.
        for (int k = 3; k >= 0; k--) begin
            if (i_sel[3-k] && ((k > int'(i_cur)) || (i_incl && (k == int'(i_cur))))) begin
                o_next = k[1:0];
                o_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_byte_ctrl.sv
// mem_byte_ctrl: serialises word-granular MEM requests into byte accesses on an 8-bit sync RAM.
// Optional MEM_BYTE_CTRL_ERR_EN adds err_o and rejects non-aligned byte-lane patterns.
module mem_byte_ctrl
    import mem_byte_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_W = RAM_ADDR_BUS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           data_i,
    input  logic [5:0]            stall_i,
    output logic [31:0]           data_o,
    output logic                  stall_req_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
`ifdef MEM_BYTE_CTRL_ERR_EN
    output logic                  err_o,
`endif
    input  logic [7:0]            ram_din_i
);

    // state    | meaning
    // MBC_IDLE | waiting for a request, RAM idle
    // MBC_RUN  | one selected byte on the RAM port per cycle
    // MBC_TAIL | load only: capture the last read byte
    // MBC_DONE | word complete, held while MEM is frozen

    mbc_state_t            r_state;
    logic                  r_we;
    logic [RAM_ADDR_W-3:0] r_base;
    logic [3:0]            r_sel;
    logic [31:0]           r_data;
    logic [1:0]            r_idx;
    logic [1:0]            r_prev;
    logic                  r_prev_vld;
    logic [31:0]           r_acc;
    logic [RAM_ADDR_W-1:0] r_ram_addr;
    logic                  r_ram_wr;
    logic [7:0]            r_ram_dout;

    logic [1:0]            w_first;
    logic                  w_first_none;
    logic [1:0]            w_next;
    logic                  w_last;
    logic                  w_req_ok;
    logic                  w_stall;
    logic                  w_unused_bits;

`ifdef MEM_BYTE_CTRL_ERR_EN
    logic                  r_err;
    assign w_req_ok = (ce_i == CHIP_ENABLE) && (sel_i != 4'b0000) && sel_legal(sel_i);
    assign err_o    = r_err;
`else
    assign w_req_ok = (ce_i == CHIP_ENABLE) && (sel_i != 4'b0000);
`endif

    lane_scan u_first (
        .i_sel  (sel_i),
        .i_cur  (2'd0),
        .i_incl (1'b1),
        .o_next (w_first),
        .o_last (w_first_none)
    );

    lane_scan u_next (
        .i_sel  (r_sel),
        .i_cur  (r_idx),
        .i_incl (1'b0),
        .o_next (w_next),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_state    <= MBC_IDLE;
            r_we       <= 1'b0;
            r_base     <= '0;
            r_sel      <= 4'b0000;
            r_data     <= 32'h0;
            r_idx      <= 2'd0;
            r_prev     <= 2'd0;
            r_prev_vld <= 1'b0;
            r_acc      <= 32'h0;
            r_ram_addr <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'h00;
`ifdef MEM_BYTE_CTRL_ERR_EN
            r_err      <= 1'b0;
`endif
        end else begin
`ifdef MEM_BYTE_CTRL_ERR_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                MBC_IDLE: begin
`ifdef MEM_BYTE_CTRL_ERR_EN
                    r_err <= (ce_i == CHIP_ENABLE) && (sel_i != 4'b0000) && !sel_legal(sel_i);
`endif
                    if (w_req_ok) begin
                        r_we       <= (we_i == WRITE_ENABLE);
                        r_base     <= addr_i[RAM_ADDR_W-1:2];
                        r_sel      <= sel_i;
                        r_data     <= data_i;
                        r_acc      <= 32'h0;
                        r_idx      <= w_first;
                        r_prev_vld <= 1'b0;
                        r_ram_addr <= {addr_i[RAM_ADDR_W-1:2], w_first};
                        r_ram_wr   <= (we_i == WRITE_ENABLE);
                        r_ram_dout <= (we_i == WRITE_ENABLE) ? lane_byte(data_i, w_first) : 8'h00;
                        r_state    <= MBC_RUN;
                    end
                end
                MBC_RUN: begin
                    // Read data lags the address by one cycle, so capture the previous lane.
                    if (!r_we && r_prev_vld) begin
                        r_acc <= lane_put(r_acc, r_prev, ram_din_i);
                    end
                    r_prev     <= r_idx;
                    r_prev_vld <= !r_we;
                    if (w_last) begin
                        r_ram_addr <= '0;
                        r_ram_wr   <= 1'b0;
                        r_ram_dout <= 8'h00;
                        r_state    <= r_we ? MBC_DONE : MBC_TAIL;
                    end else begin
                        r_idx      <= w_next;
                        r_ram_addr <= {r_base, w_next};
                        r_ram_dout <= r_we ? lane_byte(r_data, w_next) : 8'h00;
                    end
                end
                MBC_TAIL: begin
                    r_acc      <= lane_put(r_acc, r_prev, ram_din_i);
                    r_prev_vld <= 1'b0;
                    r_state    <= MBC_DONE;
                end
                MBC_DONE: begin
                    if (!stall_i[4]) begin
                        r_state <= MBC_IDLE;
                    end
                end
                default: r_state <= MBC_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            MBC_IDLE: w_stall = w_req_ok;
            MBC_RUN,
            MBC_TAIL: w_stall = 1'b1;
            default:  w_stall = 1'b0;
        endcase
    end

    assign stall_req_o = (rst != RST_ENABLE) && w_stall;
    assign data_o      = r_acc;
    assign ram_addr_o  = r_ram_addr;
    assign ram_wr_o    = r_ram_wr;
    assign ram_dout_o  = r_ram_dout;

    assign w_unused_bits = ^{stall_i[5], stall_i[3:0], addr_i[31:RAM_ADDR_W], addr_i[1:0], w_first_none};

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Directed bench for mem_byte_ctrl with a synchronous byte RAM model and write log.
// Build with MEM_BYTE_CTRL_ERR_EN defined to exercise err_o.
module tb_mem_byte_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] data_i = 32'h0;
    logic [5:0]  stall_i = 6'h0;
    logic [31:0] data_o;
    logic        stall_req_o;
    logic [16:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
`ifdef MEM_BYTE_CTRL_ERR_EN
    logic        err_o;
`endif

    mem_byte_ctrl #(.RAM_ADDR_W(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .sel_i       (sel_i),
        .data_i      (data_i),
        .stall_i     (stall_i),
        .data_o      (data_o),
        .stall_req_o (stall_req_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
`ifdef MEM_BYTE_CTRL_ERR_EN
        .err_o       (err_o),
`endif
        .ram_din_i   (ram_din_i)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:131071];
    logic [7:0]  rdata = 8'h00;
    logic        bd_we = 1'b0;
    logic [16:0] bd_a = 17'h0;
    logic [7:0]  bd_d = 8'h00;
    int          cyc = 0;
    logic [16:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    logic [16:0] ta[$];
    logic        tw[$];
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_we) begin
            mem[bd_a] <= bd_d;
        end else if (ram_wr_o) begin
            mem[ram_addr_o] <= ram_dout_o;
            wa.push_back(ram_addr_o);
            wd.push_back(ram_dout_o);
            wc.push_back(cyc);
        end
        rdata <= mem[ram_addr_o];
    end
    assign ram_din_i = rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        @(negedge clk);
        bd_a = a; bd_d = d; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
    endtask

    // Counts stalled cycles, tracing the RAM port each cycle; bounded at 40.
    task automatic wait_done(output int n);
        n = 0;
        ta.delete(); tw.delete();
        while (stall_req_o === 1'b1 && n < 40) begin
            ta.push_back(ram_addr_o);
            tw.push_back(ram_wr_o);
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data, output int n);
        @(negedge clk);
        ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
        #1;
        wait_done(n);
    endtask

    task automatic release_req();
        ce_i = 1'b0; sel_i = 4'h0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] sw_b [4];
        logic [7:0] rs_b [4];
        sw_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        rs_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_data", data_o, 32'h0);
        chk("rst_stall", 32'(stall_req_o), 32'h0);
        chk("rst_addr", 32'(ram_addr_o), 32'h0);
        chk("rst_wr", 32'(ram_wr_o), 32'h0);
        chk("rst_dout", 32'(ram_dout_o), 32'h0);
`ifdef MEM_BYTE_CTRL_ERR_EN
        chk("rst_err", 32'(err_o), 32'h0);
`endif
        rst = 1'b1;

        // SW: four consecutive byte writes, 5 stalled cycles
        clear_log();
        req(1'b1, 32'h100, 4'b1111, 32'h11223344, n);
        chk("sw_stall_cycles", 32'(n), 32'd5);
        chk("sw_done_stall", 32'(stall_req_o), 32'h0);
        chk("sw_nwr", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("sw_addr", 32'(wa[i]), 32'h100 + 32'(i));
            chk("sw_byte", 32'(wd[i]), 32'(sw_b[i]));
            chk("sw_consec", 32'(wc[i]), 32'(wc[0] + i));
        end
        release_req();

        // LB: single read of 0x203
        poke(17'h203, 8'h80);
        clear_log();
        req(1'b0, 32'h203, 4'b0001, 32'hFFFFFFFF, n);
        chk("lb_stall_cycles", 32'(n), 32'd3);
        chk("lb_rd_addr", 32'(ta[1]), 32'h203);
        chk("lb_rd_wr", 32'(tw[1]), 32'h0);
        chk("lb_data", data_o, 32'h00000080);
        chk("lb_nwr", 32'(wa.size()), 32'd0);
        release_req();

        // LW followed by 3 frozen cycles in DONE
        poke(17'h40, 8'hDE);
        poke(17'h41, 8'hAD);
        poke(17'h42, 8'hBE);
        poke(17'h43, 8'hEF);
        clear_log();
        req(1'b0, 32'h40, 4'b1111, 32'h0, n);
        chk("lw_stall_cycles", 32'(n), 32'd6);
        for (int i = 0; i < 4; i++) begin
            chk("lw_rd_addr", 32'(ta[i+1]), 32'h40 + 32'(i));
        end
        chk("lw_data", data_o, 32'hDEADBEEF);
        stall_i = 6'b010000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("hold_data", data_o, 32'hDEADBEEF);
            chk("hold_stall", 32'(stall_req_o), 32'h0);
            chk("hold_wr", 32'(ram_wr_o), 32'h0);
        end
        chk("hold_nwr", 32'(wa.size()), 32'd0);
        stall_i = 6'b000000;
        release_req();

        // SH then LH back to back
        clear_log();
        req(1'b1, 32'h12, 4'b0011, 32'hAAAA5566, n);
        chk("sh_stall_cycles", 32'(n), 32'd3);
        chk("sh_nwr", 32'(wa.size()), 32'd2);
        chk("sh_addr0", 32'(wa[0]), 32'h12);
        chk("sh_byte0", 32'(wd[0]), 32'h55);
        chk("sh_addr1", 32'(wa[1]), 32'h13);
        chk("sh_byte1", 32'(wd[1]), 32'h66);
        req(1'b0, 32'h12, 4'b0011, 32'h0, n);
        chk("lh_stall_cycles", 32'(n), 32'd4);
        chk("lh_rd_addr0", 32'(ta[1]), 32'h12);
        chk("lh_rd_addr1", 32'(ta[2]), 32'h13);
        chk("lh_data", data_o, 32'h00005566);
        release_req();

        // sel=0000: no access, no stall
        clear_log();
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h600; sel_i = 4'b0000; data_i = 32'hFFFFFFFF;
        #1;
        chk("sel0_stall", 32'(stall_req_o), 32'h0);
        @(negedge clk); #1;
        chk("sel0_stall_next", 32'(stall_req_o), 32'h0);
        chk("sel0_nwr", 32'(wa.size()), 32'd0);
        release_req();

`ifdef MEM_BYTE_CTRL_ERR_EN
        // Illegal lane pattern: one-cycle err pulse, no access
        clear_log();
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h500; sel_i = 4'b0110; data_i = 32'h00BBCC00;
        #1;
        chk("err_stall", 32'(stall_req_o), 32'h0);
        @(negedge clk);
        ce_i = 1'b0; sel_i = 4'h0;
        #1;
        chk("err_pulse", 32'(err_o), 32'h1);
        @(negedge clk); #1;
        chk("err_clear", 32'(err_o), 32'h0);
        chk("err_nwr", 32'(wa.size()), 32'd0);
`else
        // Non-contiguous lanes are serviced byte by byte
        clear_log();
        req(1'b1, 32'h500, 4'b0110, 32'h00BBCC00, n);
        chk("s0110_stall_cycles", 32'(n), 32'd3);
        chk("s0110_nwr", 32'(wa.size()), 32'd2);
        chk("s0110_addr0", 32'(wa[0]), 32'h501);
        chk("s0110_byte0", 32'(wd[0]), 32'hBB);
        chk("s0110_addr1", 32'(wa[1]), 32'h502);
        chk("s0110_byte1", 32'(wd[1]), 32'hCC);
        release_req();
`endif

        // Reset during the 2nd RUN cycle of an SW, then re-service
        clear_log();
        @(negedge clk);
        ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h300; sel_i = 4'b1111; data_i = 32'hA1B2C3D4;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rr_run2_addr", 32'(ram_addr_o), 32'h301);
        rst = 1'b0;
        #1;
        chk("rr_wr", 32'(ram_wr_o), 32'h0);
        chk("rr_addr", 32'(ram_addr_o), 32'h0);
        chk("rr_dout", 32'(ram_dout_o), 32'h0);
        chk("rr_stall", 32'(stall_req_o), 32'h0);
        chk("rr_data", data_o, 32'h0);
        chk("rr_nwr", 32'(wa.size()), 32'd1);
        rst = 1'b1;
        #1;
        wait_done(n);
        chk("rr_stall_cycles", 32'(n), 32'd5);
        chk("rr_nwr_total", 32'(wa.size()), 32'd5);
        chk("rr_first_addr", 32'(wa[0]), 32'h300);
        chk("rr_first_byte", 32'(wd[0]), 32'hA1);
        for (int i = 0; i < 4; i++) begin
            chk("rr_re_addr", 32'(wa[i+1]), 32'h300 + 32'(i));
            chk("rr_re_byte", 32'(wd[i+1]), 32'(rs_b[i]));
        end
        release_req();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_byte_ctrl.md
Name: mem_byte_ctrl

Overview:
Memory access controller directly downstream of the MEM stage.
- Takes the MEM stage's word-granular request (ce, we, addr, byte_selected, data) and serialises it into single-byte accesses on an 8-bit synchronous RAM port.
- Assembles read bytes into a 32-bit word and returns it to MEM as mem_data_i.
- Requests a pipeline stall until the access completes.

Parameters:
RAM_ADDR_W, 17, width of the byte address driven to the RAM; address is addr_i[RAM_ADDR_W-1:0].

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
ce_i  in  1  request valid (ChipEnable) from MEM stage
we_i  in  1  1 = store, 0 = load
addr_i  in  32  byte address of request
sel_i  in  4  byte-lane select; bit 3-k selects offset k
data_i  in  32  store data; offset k in data_i[31-8k:24-8k]
stall_i  in  6  pipeline stall vector; stall_i[4] = MEM frozen
data_o  out  32  assembled load word; unselected lanes 0
stall_req_o  out  1  stall request to pipeline control
ram_addr_o  out  RAM_ADDR_W  RAM byte address
ram_wr_o  out  1  RAM write strobe
ram_dout_o  out  8  RAM write data
ram_din_i  in  8  RAM read data, valid one cycle after address

Behaviour:
- Reset (rst=0, async): state=IDLE; data_o=0, stall_req_o=0, ram_addr_o=0, ram_wr_o=0, ram_dout_o=0. All internal latches and counters are cleared.
- Lane mapping is fixed: byte offset k (0..3) at address {addr_i[RAM_ADDR_W-1:2], k} maps to sel bit 3-k and data bits [31-8k:24-8k]. Offsets are processed in increasing order, skipping unselected lanes.
- stall_req_o is combinational:
  - 1 in IDLE when ce_i=1 and sel_i!=0;
  - 1 in RUN and TAIL;
  - 0 in DONE.
- States:
  - IDLE: RAM outputs idle. On ce_i=1 and sel_i!=0, latch we, base address, sel, data_i; clear data_o accumulator; set idx = lowest selected offset; go to RUN.
  - RUN: drive ram_addr_o = base+idx.
    - Store: ram_wr_o=1, ram_dout_o = the lane-idx byte.
    - Load: ram_wr_o=0. The cycle after each read address, capture ram_din_i into the lane of the previously issued offset (prev_idx with a valid flag).
    - Advance idx to the next selected offset. After the last selected offset: store goes to DONE, load goes to TAIL.
  - TAIL (load only): RAM idle; capture the final byte; go to DONE.
  - DONE: data_o holds the assembled word; RAM idle.
    - If stall_i[4]=0, go to IDLE on the next edge.
    - If stall_i[4]=1, stay in DONE holding data_o, so the request is not reissued.
- Latency in cycles with stall_req_o=1, for N selected bytes:
  - store: 1 + N;
  - load: 2 + N.
- Inputs are required stable while stall_req_o=1. Changes to inputs in RUN/TAIL are ignored because the request is latched.
- ce_i=1 with sel_i=0000: no access. The request completes in the same cycle with stall_req_o=0.
- Address arithmetic is within the word: base+idx never carries out of bits [1:0].
- Reset mid-RUN: any write in flight is abandoned; bytes already written stay written; the FSM returns to IDLE.

Optional Feature:
MEM_BYTE_CTRL_ERR_EN
- Defined: adds output err_o (1 bit), registered and reset to 0. err_o pulses for one cycle on an illegal request: ce_i=1 with sel_i not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}. An illegal request performs no RAM access and completes as if sel_i=0000.
- Undefined: err_o is absent, and any nonzero sel_i is serviced byte by byte.

Decomposition:
- defines.v:
  - RstEnable redefined to 1'b0 for this block's reset;
  - ChipEnable/WriteEnable;
  - state encodings MBC_IDLE/RUN/TAIL/DONE (2 bits);
  - RamAddrBus.
- Sub-module lane_scan (combinational): given sel[3:0] and the current offset, returns the next selected offset and a last flag. It is used for both the first-lane pick and advancing idx.

Test Plan:
- SW: ce=1, we=1, addr=0x100, sel=1111, data=0x11223344. Required: writes 0x100=11, 0x101=22, 0x102=33, 0x103=44 on 4 consecutive cycles; stall_req_o high 5 cycles, then low in DONE.
- LB: RAM[0x203]=0x80, addr=0x203, sel=0001. Required: one read of 0x203; data_o=0x00000080; stall_req_o high 3 cycles.
- LW: RAM[0x40..0x43]=DE,AD,BE,EF, sel=1111. Required: data_o=0xDEADBEEF; stall 6 cycles.
- SH then LH back-to-back: SH addr=0x12, sel=0011, data=0xAAAA5566 writes 0x12=55, 0x13=66. The following LH at addr 0x12 returns 0x00005566.
- rst=0 pulsed during the 2nd RUN cycle of an SW. Required: outputs zero immediately, state IDLE, only the first byte written; the same request is re-serviced after reset release.
- stall_i[4]=1 for 3 cycles in DONE after an LW. Required: data_o held, no new RAM access. With MEM_BYTE_CTRL_ERR_EN, sel=0110 gives err_o=1 for one cycle and no RAM access.
